// File: rtl/grid_sprite_mover.sv
// Tile-aware maze sprite mover: buffered pre-turns, instant reversal, wall stop
// and optional horizontal tunnel wrap, one update per frame_clk edge.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | spawned, no accepted move yet
// ST_MOVING  | advancing STEP pixels per frame along dir
// ST_STOPPED | aligned against a wall, waiting for a usable turn
module grid_sprite_mover #(
  parameter int COORD_W   = 10,
  parameter int TILE_LOG2 = 3,
  parameter int STEP      = 1,
  parameter int START_X   = 136,
  parameter int START_Y   = 248,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 632,
  parameter int WRAP_EN   = 1
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               respawn,
  input  logic               freeze,
  input  logic [7:0]         keycode,
  input  logic [3:0]         open_dir,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               has_moved,
  output logic               turn_pending
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MOVING  = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] X_MIN_C   = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
  localparam bit                 WRAP_C    = (WRAP_EN != 0);

  logic [1:0]         state;
  logic [1:0]         pend_dir;

  logic               req_valid;
  logic [1:0]         req_dir;
  logic               aligned;

  logic [1:0]         dir_req;
  logic               pv_req;
  logic [1:0]         pd_req;

  logic [1:0]         dir_nxt;
  logic               pv_nxt;
  logic [1:0]         pd_nxt;
  logic [1:0]         state_turn;
  logic [1:0]         state_nxt;
  logic               hm_nxt;
  logic               at_edge;
  logic               blocked;
  logic               mv_nxt;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;

  assign aligned = (pos_x[TILE_LOG2-1:0] == '0) && (pos_y[TILE_LOG2-1:0] == '0);

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_R;
    case (keycode)
      8'h07:   req_dir = DIR_R;
      8'h16:   req_dir = DIR_D;
      8'h04:   req_dir = DIR_L;
      8'h1A:   req_dir = DIR_U;
      default: req_valid = 1'b0;
    endcase
  end

  // Request stage: reversal is immediate, anything else is buffered as a pre-turn.
  always_comb begin
    dir_req = dir;
    pv_req  = turn_pending;
    pd_req  = pend_dir;
    if (req_valid) begin
      if (state == ST_MOVING && req_dir == (dir ^ 2'd2)) begin
        dir_req = req_dir;
        pv_req  = 1'b0;
      end else if (!(state == ST_MOVING && req_dir == dir)) begin
        pv_req = 1'b1;
        pd_req = req_dir;
      end
    end
  end

  // Turn stage, then motion using the heading chosen on this same edge.
  always_comb begin
    dir_nxt    = dir_req;
    pv_nxt     = pv_req;
    pd_nxt     = pd_req;
    state_turn = state;
    hm_nxt     = has_moved;
    if (pv_req && (aligned || state != ST_MOVING) && open_dir[pd_req]) begin
      dir_nxt    = pd_req;
      pv_nxt     = 1'b0;
      state_turn = ST_MOVING;
      hm_nxt     = 1'b1;
    end

    at_edge = ((dir_nxt == DIR_L) && (pos_x == X_MIN_C)) ||
              ((dir_nxt == DIR_R) && (pos_x == X_MAX_C));
    blocked = aligned && (!open_dir[dir_nxt] || (!WRAP_C && at_edge));

    state_nxt = state_turn;
    mv_nxt    = 1'b0;
    x_nxt     = pos_x;
    y_nxt     = pos_y;
    if (state_turn == ST_MOVING) begin
      if (blocked) begin
        state_nxt = ST_STOPPED;
      end else begin
        mv_nxt = 1'b1;
        case (dir_nxt)
          DIR_R:   x_nxt = at_edge ? X_MIN_C : pos_x + STEP_C;
          DIR_D:   y_nxt = pos_y + STEP_C;
          DIR_L:   x_nxt = at_edge ? X_MAX_C : pos_x - STEP_C;
          default: y_nxt = pos_y - STEP_C;
        endcase
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset || respawn) begin
      pos_x        <= START_X_C;
      pos_y        <= START_Y_C;
      dir          <= DIR_R;
      state        <= ST_IDLE;
      pend_dir     <= DIR_R;
      turn_pending <= 1'b0;
      moving       <= 1'b0;
      has_moved    <= 1'b0;
    end else if (freeze) begin
      moving <= 1'b0;
    end else begin
      pos_x        <= x_nxt;
      pos_y        <= y_nxt;
      dir          <= dir_nxt;
      state        <= state_nxt;
      pend_dir     <= pd_nxt;
      turn_pending <= pv_nxt;
      moving       <= mv_nxt;
      has_moved    <= hm_nxt;
    end
  end

endmodule

// File: tb/tb_grid_sprite_mover.sv
// Scoreboard bench for grid_sprite_mover: a wrapping instance plus a non-wrapping
// instance share one stimulus stream; expected frames are queued per edge.
module tb_grid_sprite_mover;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       respawn   = 1'b0;
  logic       freeze    = 1'b0;
  logic [7:0] keycode   = 8'h00;
  logic [3:0] open_dir  = 4'hF;

  logic [9:0] pos_x, pos_y, pos_x_nw, pos_y_nw;
  logic [1:0] dir, dir_nw;
  logic       moving, has_moved, turn_pending;
  logic       moving_nw, has_moved_nw, turn_pending_nw;

  logic [24:0] obs, obs_nw;
  logic [24:0] sb_q[$];
  int checks = 0;
  int failures = 0;

  always #5 frame_clk = ~frame_clk;

  grid_sprite_mover #(.WRAP_EN(1)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .respawn(respawn), .freeze(freeze),
    .keycode(keycode), .open_dir(open_dir), .pos_x(pos_x), .pos_y(pos_y),
    .dir(dir), .moving(moving), .has_moved(has_moved), .turn_pending(turn_pending)
  );

  grid_sprite_mover #(.WRAP_EN(0)) dut_nw (
    .frame_clk(frame_clk), .Reset(Reset), .respawn(respawn), .freeze(freeze),
    .keycode(keycode), .open_dir(open_dir), .pos_x(pos_x_nw), .pos_y(pos_y_nw),
    .dir(dir_nw), .moving(moving_nw), .has_moved(has_moved_nw), .turn_pending(turn_pending_nw)
  );

  assign obs    = {pos_x, pos_y, dir, moving, has_moved, turn_pending};
  assign obs_nw = {pos_x_nw, pos_y_nw, dir_nw, moving_nw, has_moved_nw, turn_pending_nw};

  function automatic logic [24:0] pk(input int x, input int y, input int d,
                                     input bit m, input bit h, input bit t);
    return {10'(x), 10'(y), 2'(d), m, h, t};
  endfunction

  function automatic string fmt(input logic [24:0] v);
    return $sformatf("(x=%0d y=%0d dir=%0d mv=%0b hm=%0b tp=%0b)",
                     v[24:15], v[14:5], v[4:3], v[2], v[1], v[0]);
  endfunction

  // Drive one frame's inputs away from the edge, queue the expected result, advance.
  task automatic cyc(input logic [7:0] kc, input logic [3:0] od, input logic rsp,
                     input logic frz, input logic rst, input logic [24:0] e);
    keycode  = kc;
    open_dir = od;
    respawn  = rsp;
    freeze   = frz;
    Reset    = rst;
    sb_q.push_back(e);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] e;
    cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b1, pk(136, 248, 0, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset got=%s exp=%s", fmt(obs), fmt(e)); end
    checks++;
    if (obs_nw !== pk(136, 248, 0, 0, 0, 0)) begin
      failures++; $display("FAIL reset_nw got=%s exp=%s", fmt(obs_nw), fmt(pk(136, 248, 0, 0, 0, 0)));
    end
    cyc(8'h07, 4'hF, 1'b0, 1'b0, 1'b1, pk(136, 248, 0, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_over_key got=%s exp=%s", fmt(obs), fmt(e)); end
  endtask

  task automatic test_first_move();
    logic [24:0] e;
    cyc(8'h07, 4'hF, 1'b0, 1'b0, 1'b0, pk(137, 248, 0, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL first_move got=%s exp=%s", fmt(obs), fmt(e)); end
    for (int x = 138; x <= 139; x++) begin
      cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(x, 248, 0, 1, 1, 0));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL first_run got=%s exp=%s", fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_reversal();
    logic [24:0] e;
    logic [7:0]  kcs [6];
    int          xs  [6];
    int          ds  [6];
    bit          tps [6];
    kcs = '{8'h04, 8'h07, 8'h07, 8'h16, 8'h04, 8'h07};
    xs  = '{138, 139, 140, 141, 140, 141};
    ds  = '{2, 0, 0, 0, 2, 0};
    tps = '{0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      cyc(kcs[i], 4'hF, 1'b0, 1'b0, 1'b0, pk(xs[i], 248, ds[i], 1, 1, tps[i]));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL reversal[%0d] got=%s exp=%s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_pre_turn();
    logic [24:0] e;
    cyc(8'h16, 4'hF, 1'b0, 1'b0, 1'b0, pk(142, 248, 0, 1, 1, 1));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL pre_turn_buffer got=%s exp=%s", fmt(obs), fmt(e)); end
    for (int x = 143; x <= 144; x++) begin
      cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(x, 248, 0, 1, 1, 1));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL pre_turn_wait got=%s exp=%s", fmt(obs), fmt(e)); end
    end
    cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(144, 249, 1, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL pre_turn_apply got=%s exp=%s", fmt(obs), fmt(e)); end
    cyc(8'h07, 4'hF, 1'b0, 1'b0, 1'b0, pk(144, 250, 1, 1, 1, 1));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL pre_turn2_buffer got=%s exp=%s", fmt(obs), fmt(e)); end
    for (int y = 251; y <= 256; y++) begin
      cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(144, y, 1, 1, 1, 1));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL pre_turn2_wait got=%s exp=%s", fmt(obs), fmt(e)); end
    end
    for (int x = 145; x <= 152; x++) begin
      cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(x, 256, 0, 1, 1, 0));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL pre_turn2_run got=%s exp=%s", fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_wall();
    logic [24:0] e;
    for (int i = 0; i < 2; i++) begin
      cyc(8'h00, 4'b1110, 1'b0, 1'b0, 1'b0, pk(152, 256, 0, 0, 1, 0));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL wall_stop[%0d] got=%s exp=%s", i, fmt(obs), fmt(e)); end
    end
    cyc(8'h16, 4'b1100, 1'b0, 1'b0, 1'b0, pk(152, 256, 0, 0, 1, 1));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL wall_closed_turn got=%s exp=%s", fmt(obs), fmt(e)); end
    cyc(8'h1A, 4'b1100, 1'b0, 1'b0, 1'b0, pk(152, 255, 3, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL wall_escape_up got=%s exp=%s", fmt(obs), fmt(e)); end
  endtask

  task automatic test_wrap();
    logic [24:0] e;
    cyc(8'h00, 4'hF, 1'b1, 1'b0, 1'b0, pk(136, 248, 0, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL wrap_respawn got=%s exp=%s", fmt(obs), fmt(e)); end
    cyc(8'h04, 4'hF, 1'b0, 1'b0, 1'b0, pk(135, 248, 2, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL wrap_start_left got=%s exp=%s", fmt(obs), fmt(e)); end
    for (int x = 134; x >= 0; x--) begin
      cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(x, 248, 2, 1, 1, 0));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL wrap_walk got=%s exp=%s", fmt(obs), fmt(e)); end
    end
    cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(632, 248, 2, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL wrap_to_max got=%s exp=%s", fmt(obs), fmt(e)); end
    checks++;
    if (obs_nw !== pk(0, 248, 2, 0, 1, 0)) begin
      failures++; $display("FAIL nowrap_edge got=%s exp=%s", fmt(obs_nw), fmt(pk(0, 248, 2, 0, 1, 0)));
    end
    cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(631, 248, 2, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL wrap_continue got=%s exp=%s", fmt(obs), fmt(e)); end
    checks++;
    if (obs_nw !== pk(0, 248, 2, 0, 1, 0)) begin
      failures++; $display("FAIL nowrap_hold got=%s exp=%s", fmt(obs_nw), fmt(pk(0, 248, 2, 0, 1, 0)));
    end
  endtask

  task automatic test_respawn_freeze();
    logic [24:0] e;
    logic [7:0]  fkc [5];
    fkc = '{8'h16, 8'h04, 8'h1A, 8'h16, 8'h07};
    cyc(8'h00, 4'hF, 1'b1, 1'b0, 1'b0, pk(136, 248, 0, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rf_respawn0 got=%s exp=%s", fmt(obs), fmt(e)); end
    for (int x = 137; x <= 200; x++) begin
      cyc((x == 137) ? 8'h07 : 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(x, 248, 0, 1, 1, 0));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL rf_run got=%s exp=%s", fmt(obs), fmt(e)); end
    end
    cyc(8'h07, 4'hF, 1'b1, 1'b0, 1'b0, pk(136, 248, 0, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rf_respawn_mid got=%s exp=%s", fmt(obs), fmt(e)); end
    checks++;
    if (obs_nw !== pk(136, 248, 0, 0, 0, 0)) begin
      failures++; $display("FAIL rf_respawn_nw got=%s exp=%s", fmt(obs_nw), fmt(pk(136, 248, 0, 0, 0, 0)));
    end
    cyc(8'h07, 4'hF, 1'b0, 1'b0, 1'b0, pk(137, 248, 0, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rf_restart got=%s exp=%s", fmt(obs), fmt(e)); end
    for (int i = 0; i < 5; i++) begin
      cyc(fkc[i], 4'hF, 1'b0, 1'b1, 1'b0, pk(137, 248, 0, 0, 1, 0));
      e = sb_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL rf_freeze[%0d] got=%s exp=%s", i, fmt(obs), fmt(e)); end
    end
    cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(138, 248, 0, 1, 1, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rf_unfreeze got=%s exp=%s", fmt(obs), fmt(e)); end
    cyc(8'h07, 4'hF, 1'b0, 1'b1, 1'b1, pk(136, 248, 0, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rf_reset_freeze got=%s exp=%s", fmt(obs), fmt(e)); end
    cyc(8'h00, 4'hF, 1'b0, 1'b0, 1'b0, pk(136, 248, 0, 0, 0, 0));
    e = sb_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rf_idle_after got=%s exp=%s", fmt(obs), fmt(e)); end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_reversal();
    test_pre_turn();
    test_wall();
    test_wrap();
    test_respawn_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_sprite_mover.md
Name: grid_sprite_mover

Overview:
Parametrised, tile-aware movement controller for maze sprites (Pac-Man, and ghosts driven by a synthetic keycode). It is the successor to the fixed-step keyboard mover and adds the following:
- buffered (pre-turn) direction requests, applied only on tile alignment;
- immediate reversal;
- wall stop driven by per-direction passability inputs;
- optional horizontal tunnel wrap.

It sits between the keycode/AI source and the sprite renderer and collision logic, one update per frame.

Parameters:
COORD_W, 10, coordinate width in bits
TILE_LOG2, 3, log2 of tile size in pixels (tile = 8)
STEP, 1, pixels moved per frame; must divide 2**TILE_LOG2
START_X, 136, spawn X; must be tile-aligned
START_Y, 248, spawn Y; must be tile-aligned
X_MIN, 0, leftmost legal X; tile-aligned
X_MAX, 632, rightmost legal X; tile-aligned
WRAP_EN, 1, 1 = wrap at X_MIN/X_MAX; 0 = those edges act as walls

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  synchronous, active-high reset
respawn  in  1  life lost: return to spawn (sync, one-cycle or level)
freeze  in  1  hold all state (death animation, pause)
keycode  in  8  request: 8'h07 right, 8'h16 down, 8'h04 left, 8'h1A up; anything else = no request
open_dir  in  4  bit d = neighbouring tile in direction d is passable, for the current pos (combinational maze lookup)
pos_x  out  COORD_W  current X
pos_y  out  COORD_W  current Y
dir  out  2  current heading: 0 right, 1 down, 2 left, 3 up
moving  out  1  sprite advanced on the last edge
has_moved  out  1  sticky; first accepted move since reset/respawn
turn_pending  out  1  a buffered perpendicular request is waiting

Behaviour:
- Priority per edge: Reset > respawn > freeze > normal.
- Reset and respawn: pos = (START_X, START_Y), dir = 0, state IDLE, moving = 0, has_moved = 0, pending cleared. Outputs take these values from the first edge with Reset high.
- Freeze: all registers hold. Keycodes are ignored and not buffered. moving = 0.
- aligned = low TILE_LOG2 bits of pos_x and pos_y are all zero.
- States:
  - IDLE: no motion yet.
  - MOVING.
  - STOPPED: blocked at a wall.
- Request handling on each normal edge, for a valid keycode with direction r:
  - r == dir and state MOVING: no-op.
  - r == opposite(dir) and state MOVING: dir = r immediately, no alignment needed; pending cleared.
  - Otherwise: pending = r, turn_pending = 1. A newer request overwrites the pending one.
- Turn application:
  - Turn when aligned and pending valid and open_dir[pending].
  - Or turn when state is IDLE/STOPPED (always aligned) and open_dir[pending].
  - Effect: dir = pending, pending cleared, state MOVING, has_moved = 1.
- Motion uses the dir chosen on this same edge, not the previous one. Zero added latency: the position change is visible one edge after the key is sampled.
- Blocking: if aligned and !open_dir[dir] after turn evaluation, the position holds and the state goes to MOVING -> STOPPED. A pending request is kept.
- Y has no wrap. open_dir is trusted to block vertical exits.
- X wrap:
  - WRAP_EN = 1, moving left with pos_x == X_MIN: next pos_x = X_MAX.
  - WRAP_EN = 1, moving right with pos_x == X_MAX: next pos_x = X_MIN.
  - Wrap counts as a move.
  - WRAP_EN = 0: these edges are treated as blocked regardless of open_dir.
- Arithmetic: pos ± STEP in COORD_W-bit unsigned. No other clamping; legal parameters guarantee alignment is reached exactly.
- moving = 1 exactly on edges where pos changed.

Test Plan:
1. Reset, then D (8'h07) with open_dir = 4'b1111 -> after edge 1: pos_x = 137, dir = 0, has_moved = 1, moving = 1.
2. Moving right at x = 137, press S (8'h16) once, open_dir[1] = 1 -> turn_pending = 1. x reaches 144 after 7 edges. The next edge gives pos = (144, 249), dir = 1, turn_pending = 0.
3. Reversal at x = 139 moving right, press A (8'h04) -> next edge x = 138, dir = 2.
4. Moving right, open_dir[0] = 0 at x = 152 -> x holds at 152, moving = 0, STOPPED. Then press W with open_dir[3] = 1 -> y decrements on the next edge.
5. WRAP_EN = 1, moving left at x = 0 -> next x = 632. With WRAP_EN = 0 -> x holds at 0, moving = 0.
6. respawn pulse mid-move at (200, 248) -> next edge pos = (136, 248), dir = 0, has_moved = 0. freeze high for 5 edges -> all outputs constant and keycodes ignored. Reset asserted together with freeze -> reset values.
